// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: three-master round-robin AHB arbiter with locking, hold limit and error release
module ahb_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hbusreq_1,
  input  logic       hbusreq_2,
  input  logic       hbusreq_3,
  input  logic       hlock_1,
  input  logic       hlock_2,
  input  logic       hlock_3,
  input  logic       hready,
  input  logic       hresp,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic       hgrant_3,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_data,
  output logic       hmastlock
);
  typedef enum logic [1:0] {IDLE = 2'b01, OWN = 2'b10} state_t;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  state_t     state;
  logic [1:0] owner, last, win, idx;
  logic [7:0] hold_cnt;
  logic [3:0] req, lck;
  logic [3:1] gnt;
  logic       own_req, own_lck, others, rel;
  assign req = {hbusreq_3, hbusreq_2, hbusreq_1, 1'b0};
  assign lck = {hlock_3, hlock_2, hlock_1, 1'b0};
  assign {hgrant_3, hgrant_2, hgrant_1} = gnt;
  always_comb begin
    own_req = req[owner];
    own_lck = lck[owner];
    others  = |(req & ~(4'b0001 << owner));
    rel     = (!own_req && !own_lck) || (hold_cnt == HOLD_MAX && !own_lck && others) || hresp;
    win     = 2'd0;
    idx     = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(last) + i - 1) % 3 + 1);
      win = req[idx] ? idx : win;
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last         <= 2'd3;
      hold_cnt     <= 8'd0;
      gnt          <= 3'b000;
      hmaster      <= 2'd0;
      hmaster_data <= 2'd0;
      hmastlock    <= 1'b0;
    end else if (state != IDLE && state != OWN) begin
      state    <= IDLE;
      owner    <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 3'b000;
    end else if (hready) begin
      hmaster      <= state == OWN ? owner : 2'd0;
      hmastlock    <= state == OWN && own_lck;
      hmaster_data <= hmaster;
      if (state == IDLE ? win != 2'd0 : rel && win != 2'd0) begin
        state    <= OWN;
        owner    <= win;
        last     <= win;
        hold_cnt <= 8'd0;
        gnt      <= {win == 2'd3, win == 2'd2, win == 2'd1};
      end else if (state == OWN && rel) begin
        state    <= IDLE;
        owner    <= 2'd0;
        hold_cnt <= 8'd0;
        gnt      <= 3'b000;
      end else if (state == OWN) begin
        hold_cnt <= hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed and random checks of ahb_rr_arbiter against a rule-level model
module tb_ahb_rr_arbiter;
  localparam int MAXH = 4;
  logic       hclk = 0, hresetn = 0, hready = 1, hresp = 0;
  logic [3:1] req = '0, lk = '0;
  logic       g1, g2, g3, hmastlock;
  logic [1:0] hmaster, hmaster_data;
  int         vec = 0, miss = 0;
  int         m_owner, m_last, m_cnt, m_hm, m_hmd, m_lock;

  ahb_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .hbusreq_1(req[1]), .hbusreq_2(req[2]), .hbusreq_3(req[3]),
    .hlock_1(lk[1]), .hlock_2(lk[2]), .hlock_3(lk[3]),
    .hready(hready), .hresp(hresp),
    .hgrant_1(g1), .hgrant_2(g2), .hgrant_3(g3),
    .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int from);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (from - 1 + k) % 3 + 1;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  task automatic m_reset();
    m_owner = 0; m_last = 3; m_cnt = 0; m_hm = 0; m_hmd = 0; m_lock = 0;
  endtask

  task automatic m_step();
    int w, o, oth;
    bit rel;
    if (!hready) return;
    m_hmd  = m_hm;
    m_hm   = m_owner;
    m_lock = m_owner != 0 ? int'(lk[m_owner]) : 0;
    if (m_owner == 0) begin
      w = pick(m_last);
      if (w != 0) begin m_owner = w; m_last = w; m_cnt = 0; end
    end else begin
      o = m_owner;
      oth = 0;
      for (int k = 1; k <= 3; k++) if (k != o && req[k]) oth++;
      rel = (!req[o] && !lk[o]) || (m_cnt == MAXH - 1 && !lk[o] && oth > 0) || hresp;
      if (rel) begin
        w = pick(o);
        m_owner = w;
        if (w != 0) m_last = w;
        m_cnt = 0;
      end else if (m_cnt < MAXH - 1) m_cnt++;
    end
  endtask

  task automatic m_check();
    logic [2:0] eg;
    eg = m_owner == 0 ? 3'b000 : 3'(1 << (m_owner - 1));
    chk("grant", {g3, g2, g1}, eg);
    chk("onehot", $onehot0({g3, g2, g1}), 1);
    chk("hmaster", hmaster, m_hm);
    chk("hmaster_data", hmaster_data, m_hmd);
    chk("hmastlock", hmastlock, m_lock);
  endtask

  task automatic cyc();
    @(posedge hclk);
    m_step();
    #1;
    m_check();
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {g3, g2, g1, hmaster, hmaster_data, hmastlock}, 0);
  endtask

  initial begin
    m_reset();
    #12;
    chk_zero("reset");
    @(negedge hclk);
    hresetn = 1;
    req = 3'b010;
    cyc();
    chk("req2_grant", {g3, g2, g1}, 3'b010);
    cyc();
    chk("req2_hmaster", hmaster, 2);
    cyc();
    chk("req2_hmaster_data", hmaster_data, 2);
    req = 3'b000;
    repeat (3) cyc();
    req = 3'b111;
    repeat (20) cyc();
    req = 3'b000;
    repeat (3) cyc();
    req = 3'b001; lk = 3'b001;
    for (int i = 0; i < 8 && !g1; i++) cyc();
    chk("lock_first_grant", g1, 1);
    req = 3'b101;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("lock_hold", {g3, g2, g1}, 3'b001);
    end
    chk("lock_mastlock", hmastlock, 1);
    req = 3'b100; lk = 3'b000;
    cyc();
    chk("lock_release", {g3, g2, g1}, 3'b100);
    req = 3'b000;
    repeat (3) cyc();
    req = 3'b010; lk = 3'b010;
    for (int i = 0; i < 8 && !g2; i++) cyc();
    chk("err_first_grant", g2, 1);
    repeat (2) cyc();
    req = 3'b011; hresp = 1;
    cyc();
    chk("err_handover", {g3, g2, g1}, 3'b001);
    hresp = 0;
    cyc();
    chk("err_mastlock", hmastlock, 0);
    req = 3'b000; lk = 3'b000;
    repeat (3) cyc();
    req = 3'b001;
    for (int i = 0; i < 8 && !g1; i++) cyc();
    chk("stall_first_grant", g1, 1);
    req = 3'b010; hready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_frozen", {g3, g2, g1}, 3'b001);
    end
    hready = 1;
    cyc();
    chk("stall_handover", {g3, g2, g1}, 3'b010);
    for (int i = 0; i < 400; i++) begin
      req    = 3'($urandom_range(0, 7));
      lk     = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      hready = $urandom_range(0, 3) != 0;
      hresp  = $urandom_range(0, 15) == 0;
      cyc();
    end
    req = 3'b100; lk = 3'b000; hready = 1; hresp = 0;
    for (int i = 0; i < 10 && hmaster != 2'd3; i++) cyc();
    chk("rst_pre_hmaster", hmaster, 3);
    #2 hresetn = 0;
    m_reset();
    #1;
    chk_zero("rst_mid");
    #1 hresetn = 1;
    req = 3'b111;
    cyc();
    chk("rst_first_grant", {g3, g2, g1}, 3'b001);
    repeat (12) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
